// File: rtl/edge_detect_multi_if.sv
// Bus bundle for the multi-channel edge detector: raw inputs and controls in,
// filtered levels, edge pulses and sticky flags out.
interface edge_detect_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   in;
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   clr;
    logic [CHANNELS-1:0]   level;
    logic [CHANNELS-1:0]   rise;
    logic [CHANNELS-1:0]   fall;
    // 'event' is a reserved word, so the qualified edge pulse is named evt.
    logic [CHANNELS-1:0]   evt;
    logic [CHANNELS-1:0]   pending;
    logic [CHANNELS-1:0]   overrun;
    logic                  irq;

    modport master (
        output in, mode, clr,
        input  level, rise, fall, evt, pending, overrun, irq
    );

    modport slave (
        input  in, mode, clr,
        output level, rise, fall, evt, pending, overrun, irq
    );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: synchroniser, debounce filter, mode-qualified
// edge events with sticky pending/overrun flags and an aggregated interrupt.
module edge_detect_multi #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    edge_detect_multi_if.slave bus
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] level_q, rise_q, fall_q, evt_q, pending_q, overrun_q;
    logic [CHANNELS-1:0] toggle, rise_d, fall_d, evt_d, pending_d, overrun_d;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        toggle    = '0;
        evt_d     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) toggle[i] = 1'b1;
                else                      cnt_d[i]  = cnt_q[i] + CW'(1);
            end
            evt_d[i] = (toggle[i] & ~level_q[i] & bus.mode[2*i])
                     | (toggle[i] &  level_q[i] & bus.mode[2*i+1]);
        end
        rise_d    = toggle & ~level_q;
        fall_d    = toggle &  level_q;
        // Flags follow the registered event, so a set always beats a clear.
        pending_d = evt_q | (pending_q & ~bus.clr);
        overrun_d = (evt_q & pending_q) | (overrun_q & ~bus.clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: synchronous reset; the synchroniser chain and debounce
            // counters are cleared too so partial counts never survive reset.
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < CHANNELS; i++)    cnt_q[i]  <= '0;
            level_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            evt_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            sync_q[0] <= bus.in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            for (int i = 0; i < CHANNELS; i++)    cnt_q[i]  <= cnt_d[i];
            level_q   <= level_q ^ toggle;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            evt_q     <= evt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.level   = level_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.evt     = evt_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;
    assign bus.irq     = |pending_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench: one instance without filtering (SYNC=2, DB=1) and one with
// a 4-cycle debounce (SYNC=2, DB=4), sharing clock and reset.
module tb_edge_detect_multi;

    logic clk;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    edge_detect_multi_if #(.CHANNELS(4)) ifa ();
    edge_detect_multi_if #(.CHANNELS(4)) ifb ();

    edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ifa.in   = 4'hF;
        ifa.mode = 8'h55;
        ifa.clr  = 4'h0;
        ifb.in   = 4'h0;
        ifb.mode = 8'h55;
        ifb.clr  = 4'h0;
        tick(2);

        // Reset state
        check("rst_a_level",   ifa.level,   4'h0);
        check("rst_a_rise",    ifa.rise,    4'h0);
        check("rst_a_pending", ifa.pending, 4'h0);
        check("rst_a_irq",     ifa.irq,     1'b0);
        check("rst_b_level",   ifb.level,   4'h0);
        check("rst_b_evt",     ifb.evt,     4'h0);

        // Test 1: input held high through reset, release at edge 0
        rst_n = 1'b1;
        tick();                                   // edge 0
        check("t1_e0_level", ifa.level, 4'h0);
        tick();                                   // edge 1
        check("t1_e1_level", ifa.level, 4'h0);
        tick();                                   // edge 2
        check("t1_e2_level",   ifa.level,   4'hF);
        check("t1_e2_rise",    ifa.rise,    4'hF);
        check("t1_e2_evt",     ifa.evt,     4'hF);
        check("t1_e2_pending", ifa.pending, 4'h0);
        tick();                                   // edge 3
        check("t1_e3_rise",    ifa.rise,    4'h0);
        check("t1_e3_pending", ifa.pending, 4'hF);
        check("t1_e3_irq",     ifa.irq,     1'b1);

        // Bring channels back low with all modes off, clearing flags
        ifa.mode = 8'h00;
        ifa.clr  = 4'hF;
        ifa.in   = 4'h0;
        tick();                                   // edge 4
        check("t3_clr_pending", ifa.pending, 4'h0);
        check("t3_clr_irq",     ifa.irq,     1'b0);
        ifa.clr = 4'h0;
        tick(2);                                  // edge 6
        check("t3_off_fall", ifa.fall, 4'hF);
        check("t3_off_evt",  ifa.evt,  4'h0);
        tick();                                   // edge 7
        check("t3_off_pending", ifa.pending, 4'h0);

        // Test 3: modes ch0..3 = 00/01/10/11
        ifa.mode = 8'b11_10_01_00;
        ifa.in   = 4'hF;
        tick(3);                                  // edge 10
        check("t3_rise",       ifa.rise,  4'hF);
        check("t3_rise_evt",   ifa.evt,   4'hA);
        check("t3_rise_level", ifa.level, 4'hF);
        tick();                                   // edge 11
        check("t3_rise_pending", ifa.pending, 4'hA);
        check("t3_rise_once",    ifa.rise,    4'h0);
        ifa.in = 4'h0;
        tick(3);                                  // edge 14
        check("t3_fall",     ifa.fall, 4'hF);
        check("t3_fall_evt", ifa.evt,  4'hC);
        check("t3_no_rise",  ifa.rise, 4'h0);
        tick();                                   // edge 15
        check("t3_pending", ifa.pending, 4'hE);
        check("t3_overrun", ifa.overrun, 4'h8);

        // Test 4: clr[1] collides with a new registered event on ch1
        ifa.in = 4'b0010;
        tick(3);                                  // edge 18
        check("t4_evt", ifa.evt, 4'h2);
        ifa.clr = 4'b0010;
        tick();                                   // edge 19
        check("t4_race_pending", ifa.pending, 4'hE);
        check("t4_race_overrun", ifa.overrun, 4'hA);
        tick();                                   // edge 20
        check("t4_clr_pending", ifa.pending, 4'hC);
        check("t4_clr_overrun", ifa.overrun, 4'h8);
        check("t4_irq_held",    ifa.irq,     1'b1);
        ifa.clr = 4'hF;
        tick();                                   // edge 21
        check("t4_all_pending", ifa.pending, 4'h0);
        check("t4_all_overrun", ifa.overrun, 4'h0);
        check("t4_irq_drop",    ifa.irq,     1'b0);
        ifa.clr = 4'h0;

        // Test 5: overrun on ch2 in both-edge mode
        ifa.mode = 8'b11_11_01_00;
        ifa.in   = 4'b0110;
        tick(3);                                  // edge 24
        check("t5_e1_rise", ifa.rise, 4'h4);
        check("t5_e1_evt",  ifa.evt,  4'h4);
        tick();
        check("t5_e1_pending", ifa.pending, 4'h4);
        check("t5_e1_overrun", ifa.overrun, 4'h0);
        ifa.in = 4'b0010;
        tick(3);
        check("t5_e2_fall", ifa.fall, 4'h4);
        check("t5_e2_evt",  ifa.evt,  4'h4);
        tick();
        check("t5_e2_pending", ifa.pending, 4'h4);
        check("t5_e2_overrun", ifa.overrun, 4'h4);
        ifa.in = 4'b0110;
        tick(4);
        check("t5_e3_pending", ifa.pending, 4'h4);
        check("t5_e3_overrun", ifa.overrun, 4'h4);

        // Test 2: 3-cycle glitch on ch0 is filtered out
        ifb.in = 4'h1;
        tick(3);
        ifb.in = 4'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t2_glitch_level_%0d", i), ifb.level, 4'h0);
            check($sformatf("t2_glitch_rise_%0d", i),  ifb.rise,  4'h0);
        end
        check("t2_glitch_pending", ifb.pending, 4'h0);

        // Clean step: level flips after edge k+5
        ifb.in = 4'h1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t2_wait_level_%0d", i), ifb.level, 4'h0);
        end
        tick();
        check("t2_level", ifb.level, 4'h1);
        check("t2_rise",  ifb.rise,  4'h1);
        check("t2_evt",   ifb.evt,   4'h1);
        tick();
        check("t2_rise_once", ifb.rise,    4'h0);
        check("t2_pending",   ifb.pending, 4'h1);

        // Test 6: reset while ch1 counter sits at 2 of 4
        ifb.in = 4'b0011;
        tick(4);
        rst_n = 1'b0;
        tick();
        check("t6_rst_b_level",   ifb.level,   4'h0);
        check("t6_rst_b_pending", ifb.pending, 4'h0);
        check("t6_rst_b_irq",     ifb.irq,     1'b0);
        check("t6_rst_a_level",   ifa.level,   4'h0);
        check("t6_rst_a_overrun", ifa.overrun, 4'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_wait_level_%0d", i), ifb.level, 4'h0);
        end
        tick();
        check("t6_level", ifb.level, 4'h3);
        check("t6_rise",  ifb.rise,  4'h3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Parametrised multi-channel edge detector. It generalises the single-bit rising edge detector with an input synchroniser, a debounce filter, per-channel edge-mode selection, and sticky event/overrun flags. It serves as the common front end for asynchronous buttons, switches and external strobes feeding the control logic. It also aggregates an interrupt request.

Parameters:
CHANNELS, 4, number of independent input channels (>=1).
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2).
DEBOUNCE_CYCLES, 1, consecutive cycles the synchronised input must differ from the filtered level before the level flips (>=1; 1 = no filtering).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
in  input  CHANNELS  raw, possibly asynchronous, inputs.
mode  input  2*CHANNELS  per-channel qualifier, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
clr  input  CHANNELS  write-1-to-clear for pending[i] and overrun[i], sampled each clock.
level  output  CHANNELS  synchronised, debounced level.
rise  output  CHANNELS  1-cycle pulse when level[i] goes 0->1 (mode-independent).
fall  output  CHANNELS  1-cycle pulse when level[i] goes 1->0 (mode-independent).
event  output  CHANNELS  1-cycle pulse of mode-qualified edge.
pending  output  CHANNELS  sticky, set by event[i].
overrun  output  CHANNELS  sticky, set by event[i] while pending[i] already 1.
irq  output  1  OR of pending.

Behaviour:
- Reset (rst_n=0 at a clk edge): all synchroniser flops, level, debounce counters, rise, fall, event, pending and overrun go to 0. irq is 0 on the next cycle.
- Reset has priority over all other inputs. Reset mid-debounce discards partial counts.
- An input held high through reset produces a rise after reset release, at normal latency.
- Synchroniser: shift chain of SYNC_STAGES flops. s[i] is the last stage.
- Debounce, per channel:
  - counter width clog2(DEBOUNCE_CYCLES+1).
  - Each clock with s[i]!=level[i]: if cnt==DEBOUNCE_CYCLES-1, then level[i] toggles and cnt<=0; else cnt<=cnt+1.
  - Each clock with s[i]==level[i]: cnt<=0. A glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
- Edge outputs are registered and assert in the same cycle level[i] takes its new value, for exactly one cycle:
  - rise = level toggled to 1.
  - fall = level toggled to 0.
- Latency: a clean input step settling before clk edge k makes level/rise/fall change after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=1 gives the change after edge k+2.
- event[i] is registered alongside rise/fall: 1 when (rise condition and mode bit0) or (fall condition and mode bit1).
  - mode is sampled on the same edge that flips level. Changing mode never creates or cancels an already-registered event.
- pending[i] next-state: set if event qualifies this edge, else cleared if clr[i], else hold.
  - Event is visible in pending one cycle after the event pulse. Simultaneous qualifying edge and clr: set wins, pending stays 1.
- overrun[i]: set when a new qualifying edge is registered while pending[i]==1. Cleared by clr[i]; set wins over clr.
- irq: combinational OR of pending.
- Channels are fully independent. No cross-channel interaction except irq.
- Max edge rate: one level change per DEBOUNCE_CYCLES cycles per channel.

Test Plan:
1. Reset/hold: in=4'hF held through reset; release at edge 0 (SYNC=2, DB=1, mode all 01) -> level=4'hF and rise=4'hF for one cycle at edge 2; pending=4'hF at edge 3; irq=1.
2. Debounce: DEBOUNCE_CYCLES=4; on ch0, pulse in 3 cycles high, then low -> no level/rise/event. Then hold high 4+ cycles -> level[0]=1 exactly SYNC_STAGES+3 edges after the step.
3. Modes: ch0..3 modes 00/01/10/11; toggle all inputs 0->1->0 with settled gaps. Expected:
   - rise and fall each pulse once on all channels.
   - event fires on ch1 (rise only), ch2 (fall only), ch3 (twice).
   - ch0 event and pending stay 0.
4. Sticky/clear race: pending[1]=1, assert clr[1] on the same edge a new qualifying rise registers -> pending[1] stays 1 and overrun[1]=1. Next cycle clr[1]=1 alone -> both 0; irq drops if no other pending.
5. Overrun: ch2 mode 11, no clr; two edges -> pending[2]=1 after the first, overrun[2]=1 after the second. A third edge leaves both at 1.
6. Reset mid-operation: debounce counter at 2 of 4 with in high; assert rst_n=0 for one edge -> all outputs 0. After release, level needs a full SYNC+4-1 edges to rise.
